// File: rtl/pong_engine.sv
// ============================================================================
// Module      : pong_engine
// Description : Per-frame Pong game-state engine. On each rising edge of
//               end_frame it moves the paddles from the button levels,
//               advances the ball, resolves wall bounces, paddle hits and
//               goals, and keeps the score.
//               Optional feature macro: PONG_SPEEDUP_EN (each paddle hit
//               raises the ball step by one, up to 6; reset on every serve).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pong_engine #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int PAD_W        = 10,
  parameter int PAD_H        = 80,
  parameter int PAD1_X       = 20,
  parameter int PAD2_X       = 610,
  parameter int BALL_SIZE    = 10,
  parameter int PAD_STEP     = 4,
  parameter int BALL_STEP    = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       end_frame,
  input  logic       p1_up,
  input  logic       p1_down,
  input  logic       p2_up,
  input  logic       p2_down,
  output logic [9:0] y1,
  output logic [9:0] y2,
  output logic [9:0] xb,
  output logic [9:0] yb,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] point,
  output logic       game_over
);

  // Geometry derived from the parameters, pre-sized to the datapath widths
  localparam logic [9:0]  c_pad_step   = 10'(PAD_STEP);
  localparam logic [9:0]  c_pad_ymax   = 10'(SCREEN_H - PAD_H);
  localparam logic [9:0]  c_pad_init   = 10'((SCREEN_H - PAD_H) / 2);
  localparam logic [9:0]  c_ball_ymax  = 10'(SCREEN_H - BALL_SIZE);
  localparam logic [10:0] c_ball_xmax  = 11'(SCREEN_W - BALL_SIZE);
  localparam logic [10:0] c_ball_sz    = 11'(BALL_SIZE);
  localparam logic [10:0] c_pad_h      = 11'(PAD_H);
  localparam logic [10:0] c_pad2_x     = 11'(PAD2_X);
  localparam logic [9:0]  c_pad2_stop  = 10'(PAD2_X - BALL_SIZE);
  localparam logic [9:0]  c_pad1_face  = 10'(PAD1_X + PAD_W);
  localparam logic [9:0]  c_ctr_x      = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [9:0]  c_ctr_y      = 10'((SCREEN_H - BALL_SIZE) / 2);
  localparam int          CNT_W        = $clog2(SERVE_FRAMES + 1);
  localparam logic [CNT_W-1:0] c_serve = CNT_W'(SERVE_FRAMES);
  localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);
  localparam logic [3:0]  c_win        = 4'(WIN_SCORE);
  localparam logic [2:0]  c_step_init  = 3'(BALL_STEP);
`ifdef PONG_SPEEDUP_EN
  localparam logic [2:0]  c_step_max   = 3'd6;
`endif

  typedef enum logic [1:0] {
    ST_SERVE    = 2'd0,
    ST_PLAY     = 2'd1,
    ST_GAMEOVER = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_ef_d;
  logic [CNT_W-1:0] r_cnt;
  logic [9:0]       r_y1, r_y2, r_xb, r_yb;
  logic [3:0]       r_s1, r_s2;
  logic [1:0]       r_point;
  logic             r_game_over;
  logic             r_dx;   // 1 = moving right
  logic             r_dy;   // 1 = moving down

  logic             w_tick;
  logic [2:0]       w_step;
  logic [9:0]       w_step10;
  logic [10:0]      w_step11;
  logic [9:0]       w_y1_nx, w_y2_nx;
  logic [9:0]       w_yb_nx, w_xb_nx;
  logic             w_dy_nx, w_dx_nx;
  logic [10:0]      w_ysum;
  logic [10:0]      w_nx_r;
  logic [9:0]       w_nx_l;
  logic             w_ov1, w_ov2;
  logic             w_hit, w_goal1, w_goal2;
  logic [3:0]       w_s1_inc, w_s2_inc;

`ifdef PONG_SPEEDUP_EN
  logic [2:0]       r_step;
  assign w_step = r_step;
`else
  assign w_step = c_step_init;
`endif

  assign w_step10 = {7'd0, w_step};
  assign w_step11 = {8'd0, w_step};

  // History flop resets high so a level already high out of reset is not a tick
  assign w_tick = end_frame & ~r_ef_d;

  // Paddle step: up and down are exclusive, both or neither holds position
  function automatic logic [9:0] f_pad(input logic [9:0] y, input logic up,
                                       input logic dn);
    logic [10:0] sum;
    sum = {1'b0, y} + {1'b0, c_pad_step};
    if (up && !dn)
      return (y >= c_pad_step) ? (y - c_pad_step) : 10'd0;
    else if (dn && !up)
      return (sum >= {1'b0, c_pad_ymax}) ? c_pad_ymax : sum[9:0];
    else
      return y;
  endfunction

  assign w_y1_nx  = f_pad(r_y1, p1_up, p1_down);
  assign w_y2_nx  = f_pad(r_y2, p2_up, p2_down);

  assign w_ysum   = {1'b0, r_yb} + w_step11;
  assign w_nx_r   = {1'b0, r_xb} + w_step11;
  assign w_nx_l   = r_xb - w_step10;

  // Vertical overlap of the ball with each paddle, using pre-tick positions
  assign w_ov1 = (({1'b0, r_yb} + c_ball_sz) > {1'b0, r_y1}) &&
                 ({1'b0, r_yb} < ({1'b0, r_y1} + c_pad_h));
  assign w_ov2 = (({1'b0, r_yb} + c_ball_sz) > {1'b0, r_y2}) &&
                 ({1'b0, r_yb} < ({1'b0, r_y2} + c_pad_h));

  assign w_s1_inc = (r_s1 == 4'hF) ? r_s1 : (r_s1 + 4'd1);
  assign w_s2_inc = (r_s2 == 4'hF) ? r_s2 : (r_s2 + 4'd1);

  // Ball motion candidate for a PLAY tick: wall bounce, paddle hit or goal
  always_comb begin
    w_yb_nx = r_yb;
    w_dy_nx = r_dy;
    w_xb_nx = r_xb;
    w_dx_nx = r_dx;
    w_hit   = 1'b0;
    w_goal1 = 1'b0;
    w_goal2 = 1'b0;

    if (r_dy) begin
      if (w_ysum >= {1'b0, c_ball_ymax}) begin
        w_yb_nx = c_ball_ymax;
        w_dy_nx = 1'b0;
      end else begin
        w_yb_nx = w_ysum[9:0];
      end
    end else begin
      if (r_yb <= w_step10) begin
        w_yb_nx = 10'd0;
        w_dy_nx = 1'b1;
      end else begin
        w_yb_nx = r_yb - w_step10;
      end
    end

    if (r_dx) begin
      // Ball must start in front of paddle 2 and reach or cross its face
      if ((({1'b0, r_xb} + c_ball_sz) <= c_pad2_x) &&
          ((w_nx_r + c_ball_sz) >= c_pad2_x) && w_ov2) begin
        w_hit   = 1'b1;
        w_xb_nx = c_pad2_stop;
        w_dx_nx = 1'b0;
      end else if (w_nx_r >= c_ball_xmax) begin
        w_goal1 = 1'b1;
      end else begin
        w_xb_nx = w_nx_r[9:0];
      end
    end else begin
      // r_xb >= face guards the subtraction against wrap-around
      if ((r_xb >= c_pad1_face) && (w_nx_l <= c_pad1_face) && w_ov1) begin
        w_hit   = 1'b1;
        w_xb_nx = c_pad1_face;
        w_dx_nx = 1'b1;
      end else if (r_xb <= w_step10) begin
        w_goal2 = 1'b1;
      end else begin
        w_xb_nx = w_nx_l;
      end
    end
  end

  // Game state machine: all state and outputs update only on ticks
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_SERVE;
      r_ef_d      <= 1'b1;
      r_cnt       <= '0;
      r_y1        <= c_pad_init;
      r_y2        <= c_pad_init;
      r_xb        <= c_ctr_x;
      r_yb        <= c_ctr_y;
      r_s1        <= 4'd0;
      r_s2        <= 4'd0;
      r_point     <= 2'b00;
      r_game_over <= 1'b0;
      r_dx        <= 1'b1;
      r_dy        <= 1'b1;
`ifdef PONG_SPEEDUP_EN
      r_step      <= c_step_init;
`endif
    end else begin
      r_ef_d  <= end_frame;
      r_point <= 2'b00;
      if (w_tick) begin
        case (r_state)
          ST_SERVE: begin
            r_y1 <= w_y1_nx;
            r_y2 <= w_y2_nx;
            if (r_cnt == c_serve) begin
              r_state <= ST_PLAY;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + c_one;
            end
          end
          ST_PLAY: begin
            r_y1 <= w_y1_nx;
            r_y2 <= w_y2_nx;
            r_yb <= w_yb_nx;
            r_dy <= w_dy_nx;
            if (w_goal1 || w_goal2) begin
              // Recentre, serve toward the left after a player-1 point
              r_xb  <= c_ctr_x;
              r_yb  <= c_ctr_y;
              r_cnt <= '0;
`ifdef PONG_SPEEDUP_EN
              r_step <= c_step_init;
`endif
              if (w_goal1) begin
                r_s1    <= w_s1_inc;
                r_point <= 2'b01;
                r_dx    <= 1'b0;
                if (w_s1_inc == c_win) begin
                  r_state     <= ST_GAMEOVER;
                  r_game_over <= 1'b1;
                end else begin
                  r_state <= ST_SERVE;
                end
              end else begin
                r_s2    <= w_s2_inc;
                r_point <= 2'b10;
                r_dx    <= 1'b1;
                if (w_s2_inc == c_win) begin
                  r_state     <= ST_GAMEOVER;
                  r_game_over <= 1'b1;
                end else begin
                  r_state <= ST_SERVE;
                end
              end
            end else begin
              r_xb <= w_xb_nx;
              r_dx <= w_dx_nx;
`ifdef PONG_SPEEDUP_EN
              if (w_hit && (r_step < c_step_max))
                r_step <= r_step + 3'd1;
`endif
            end
          end
          ST_GAMEOVER: begin
            r_game_over <= 1'b1;
          end
          default: begin
            r_state <= ST_SERVE;
          end
        endcase
      end
    end
  end

  assign y1        = r_y1;
  assign y2        = r_y2;
  assign xb        = r_xb;
  assign yb        = r_yb;
  assign score1    = r_s1;
  assign score2    = r_s2;
  assign point     = r_point;
  assign game_over = r_game_over;

endmodule

`default_nettype wire

// File: tb/tb_pong_engine.sv
// ============================================================================
// Module      : tb_pong_engine
// Description : Directed self-checking bench for pong_engine. Ticks are a
//               one-cycle end_frame pulse; outputs are sampled on the
//               falling clock edge. Expected values are hand-derived.
//               Honours PONG_SPEEDUP_EN for speed-dependent expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pong_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       end_frame = 1'b0;
  logic       p1_up = 1'b0, p1_down = 1'b0, p2_up = 1'b0, p2_down = 1'b0;
  logic [9:0] y1, y2, xb, yb;
  logic [3:0] score1, score2;
  logic [1:0] point;
  logic       game_over;

  int vectors = 0;
  int errors  = 0;

  localparam logic [49:0] c_rst_vec = {10'd200, 10'd200, 10'd315, 10'd235,
                                       4'd0, 4'd0, 2'b00, 1'b0, 1'b1};

  always #5 clk = ~clk;

  pong_engine dut (
    .clk       (clk),
    .rst       (rst),
    .end_frame (end_frame),
    .p1_up     (p1_up),
    .p1_down   (p1_down),
    .p2_up     (p2_up),
    .p2_down   (p2_down),
    .y1        (y1),
    .y2        (y2),
    .xb        (xb),
    .yb        (yb),
    .score1    (score1),
    .score2    (score2),
    .point     (point),
    .game_over (game_over)
  );

  // One tick: end_frame high for one rising clock edge, then low again.
  // Returns on the falling edge right after the update, while point is valid.
  task automatic tick();
    @(negedge clk) end_frame = 1'b1;
    @(negedge clk) end_frame = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; end_frame = 1'b0;
    p1_up = 1'b0; p1_down = 1'b0; p2_up = 1'b0; p2_down = 1'b0;
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  // Paddle 1 follows the ball centre so the left side never concedes
  task automatic track_p1();
    int pc, bc;
    pc = int'(y1) + 40;
    bc = int'(yb) + 5;
    p1_up   = (pc > bc + 2);
    p1_down = (pc < bc - 2);
  endtask

  task automatic test_reset();
    logic [49:0] obs;
    do_reset();
    obs = {y1, y2, xb, yb, score1, score2, point, game_over, 1'b1};
    vectors++;
    if (obs !== c_rst_vec) begin
      errors++;
      $display("FAIL reset_values: got %h, want %h", obs, c_rst_vec);
    end
  endtask

  task automatic test_paddles();
    int exp_y;
    do_reset();
    p1_up = 1'b1;
    for (int k = 1; k <= 51; k++) begin
      tick();
      exp_y = (k <= 50) ? 200 - 4 * k : 0;
      vectors++;
      if (y1 !== 10'(exp_y)) begin
        errors++;
        $display("FAIL p1_up tick %0d: y1=%0d, want %0d", k, y1, exp_y);
      end
    end
    p1_up = 1'b0; p1_down = 1'b1;
    repeat (3) tick();
    vectors++;
    if (y1 !== 10'd12) begin
      errors++;
      $display("FAIL p1_down: y1=%0d, want 12", y1);
    end
    p1_up = 1'b1;
    repeat (3) tick();
    vectors++;
    if (y1 !== 10'd12 || y2 !== 10'd200) begin
      errors++;
      $display("FAIL both_pressed: y1=%0d y2=%0d, want 12 200", y1, y2);
    end
    vectors++;
    if (xb !== 10'd315 || yb !== 10'd235) begin
      errors++;
      $display("FAIL serve_during_paddles: xb=%0d yb=%0d, want 315 235", xb, yb);
    end
  endtask

  task automatic test_ball();
    do_reset();
    for (int t = 1; t <= 219; t++) begin
      tick();
      if (t <= 61) begin
        vectors++;
        if (xb !== 10'd315 || yb !== 10'd235) begin
          errors++;
          $display("FAIL serve_hold t=%0d: xb=%0d yb=%0d, want 315 235", t, xb, yb);
        end
      end
      if (t == 62) begin
        vectors++;
        if (xb !== 10'd317 || yb !== 10'd237) begin
          errors++;
          $display("FAIL first_move: xb=%0d yb=%0d, want 317 237", xb, yb);
        end
      end
      if (t == 178 || t == 179) begin
        vectors++;
        if (yb !== ((t == 178) ? 10'd469 : 10'd470)) begin
          errors++;
          $display("FAIL bottom_wall t=%0d: yb=%0d, want %0d", t, yb,
                   (t == 178) ? 469 : 470);
        end
      end
      if (t == 180) begin
        vectors++;
        if (yb !== 10'd468 || xb !== 10'd553) begin
          errors++;
          $display("FAIL after_bounce: xb=%0d yb=%0d, want 553 468", xb, yb);
        end
      end
      if (t == 218) begin
        vectors++;
        if (xb !== 10'd629 || point !== 2'b00 || score1 !== 4'd0) begin
          errors++;
          $display("FAIL pre_goal: xb=%0d point=%b s1=%0d, want 629 00 0",
                   xb, point, score1);
        end
      end
    end
    vectors++;
    if (point !== 2'b01 || score1 !== 4'd1 || score2 !== 4'd0 ||
        xb !== 10'd315 || yb !== 10'd235 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL goal_p1: point=%b s1=%0d s2=%0d xb=%0d yb=%0d go=%b, want 01 1 0 315 235 0",
               point, score1, score2, xb, yb, game_over);
    end
    @(negedge clk);
    vectors++;
    if (point !== 2'b00) begin
      errors++;
      $display("FAIL point_pulse_width: point=%b, want 00", point);
    end
    for (int t = 220; t <= 281; t++) begin
      tick();
      if (t == 280) begin
        vectors++;
        if (xb !== 10'd315 || yb !== 10'd235) begin
          errors++;
          $display("FAIL reserve_hold: xb=%0d yb=%0d, want 315 235", xb, yb);
        end
      end
    end
    vectors++;
    if (xb !== 10'd313 || yb !== 10'd233) begin
      errors++;
      $display("FAIL reserve_dir: xb=%0d yb=%0d, want 313 233", xb, yb);
    end
  endtask

  task automatic test_paddle_hit();
    logic [9:0] prev;
    logic       turned;
    do_reset();
    p2_down = 1'b1;
    for (int t = 1; t <= 205; t++) begin
      tick();
      if (t == 49 || t == 50 || t == 51) begin
        vectors++;
        if (y2 !== ((t == 49) ? 10'd396 : 10'd400)) begin
          errors++;
          $display("FAIL p2_clamp t=%0d: y2=%0d, want %0d", t, y2,
                   (t == 49) ? 396 : 400);
        end
      end
      if (t == 203) begin
        vectors++;
        if (xb !== 10'd599 || yb !== 10'd422) begin
          errors++;
          $display("FAIL pre_hit: xb=%0d yb=%0d, want 599 422", xb, yb);
        end
      end
      if (t == 204) begin
        vectors++;
        if (xb !== 10'd600 || yb !== 10'd420 || score1 !== 4'd0 || point !== 2'b00) begin
          errors++;
          $display("FAIL p2_hit: xb=%0d yb=%0d s1=%0d point=%b, want 600 420 0 00",
                   xb, yb, score1, point);
        end
      end
    end
`ifdef PONG_SPEEDUP_EN
    vectors++;
    if (xb !== 10'd597 || yb !== 10'd417) begin
      errors++;
      $display("FAIL after_hit_fast: xb=%0d yb=%0d, want 597 417", xb, yb);
    end
    turned = 1'b0;
    for (int t = 0; t < 400 && !turned; t++) begin
      track_p1();
      prev = xb;
      tick();
      turned = (xb > prev);
    end
    vectors++;
    if (xb !== 10'd34) begin
      errors++;
      $display("FAIL second_hit_step: xb=%0d, want 34", xb);
    end
    p1_up = 1'b0; p1_down = 1'b0;
`else
    prev   = 10'd0;
    turned = 1'b0;
    vectors++;
    if (xb !== 10'd598 || yb !== 10'd418 || turned !== 1'b0 || prev !== 10'd0) begin
      errors++;
      $display("FAIL after_hit: xb=%0d yb=%0d, want 598 418", xb, yb);
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic [49:0] obs;
    // Rising end_frame and rst in the same cycle, mid-PLAY
    @(negedge clk);
    end_frame = 1'b1; rst = 1'b1; p1_down = 1'b1;
    @(negedge clk);
    obs = {y1, y2, xb, yb, score1, score2, point, game_over, 1'b1};
    vectors++;
    if (obs !== c_rst_vec) begin
      errors++;
      $display("FAIL reset_priority: got %h, want %h", obs, c_rst_vec);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    vectors++;
    if (y1 !== 10'd200) begin
      errors++;
      $display("FAIL no_tick_after_reset: y1=%0d, want 200", y1);
    end
    end_frame = 1'b0;
    @(negedge clk) end_frame = 1'b1;
    repeat (100) @(negedge clk);
    end_frame = 1'b0;
    @(negedge clk);
    vectors++;
    if (y1 !== 10'd204 || xb !== 10'd315) begin
      errors++;
      $display("FAIL held_end_frame: y1=%0d xb=%0d, want 204 315", y1, xb);
    end
    p1_down = 1'b0;
  endtask

  task automatic test_game_over();
    int         goals;
    logic [9:0] snap_y1, snap_y2;
    do_reset();
    goals = 0;
    for (int t = 0; t < 20000 && game_over !== 1'b1; t++) begin
      track_p1();
      // Paddle 2 keeps to the half of the screen away from the ball
      if (int'(yb) + 5 < 240) begin
        p2_down = 1'b1; p2_up = 1'b0;
      end else begin
        p2_down = 1'b0; p2_up = 1'b1;
      end
      tick();
      if (point !== 2'b00) begin
        goals++;
        vectors++;
        if (point !== 2'b01 || score1 !== 4'(goals) || score2 !== 4'd0) begin
          errors++;
          $display("FAIL goal_%0d: point=%b s1=%0d s2=%0d, want 01 %0d 0",
                   goals, point, score1, score2, goals);
        end
      end
    end
    vectors++;
    if (game_over !== 1'b1 || score1 !== 4'd9 || score2 !== 4'd0 ||
        xb !== 10'd315 || yb !== 10'd235) begin
      errors++;
      $display("FAIL game_over_entry: go=%b s1=%0d s2=%0d xb=%0d yb=%0d, want 1 9 0 315 235",
               game_over, score1, score2, xb, yb);
    end
    snap_y1 = y1;
    snap_y2 = y2;
    p1_up = 1'b1; p1_down = 1'b0; p2_up = 1'b0; p2_down = 1'b1;
    repeat (120) tick();
    vectors++;
    if (game_over !== 1'b1 || score1 !== 4'd9 || score2 !== 4'd0 || point !== 2'b00 ||
        xb !== 10'd315 || yb !== 10'd235 || y1 !== snap_y1 || y2 !== snap_y2) begin
      errors++;
      $display("FAIL game_over_frozen: go=%b s1=%0d xb=%0d yb=%0d y1=%0d y2=%0d, want 1 9 315 235 %0d %0d",
               game_over, score1, xb, yb, y1, y2, snap_y1, snap_y2);
    end
  endtask

  initial begin
    test_reset();
    test_paddles();
    test_ball();
    test_paddle_hit();
    test_reset_mid();
    test_game_over();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
